// File: rtl/mu0_reg12_tx_if.sv
// Parallel-in / serial-out link bundle for the MU0 12-bit register transmitter.
// The master side drives Start/D; the slave (transmitter) side returns TxD/Busy/Done.
interface mu0_reg12_tx_if;
    logic        Start;
    logic [11:0] D;
    logic        TxD;
    logic        Busy;
    logic        Done;

    modport master (output Start, output D, input TxD, input Busy, input Done);
    modport slave  (input Start, input D, output TxD, output Busy, output Done);
endinterface

// File: rtl/mu0_reg12_tx.sv
// MU0 register-link transmitter: 12-bit word out as start, 12 data LSB first, even parity, stop.
// Start bit appears 1 cycle after an accepted Start; Start is ignored (not queued) while Busy.
module mu0_reg12_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    mu0_reg12_tx_if.slave      bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [7:0]  baud_q, baud_d;
    logic [3:0]  bit_q, bit_d;
    logic [11:0] shift_q, shift_d;
    logic        par_q, par_d;
    logic        txd_q, txd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Outputs are computed for the bit about to start, so TxD/Busy/Done leave flops directly.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        txd_d   = txd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (bus.Start) begin
                    state_d = ST_START;
                    shift_d = bus.D;
                    par_d   = ^bus.D;
                    baud_d  = '0;
                    bit_d   = '0;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = ST_DATA;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d = baud_q + 8'd1;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 4'd11) begin
                        state_d = ST_PARITY;
                        txd_d   = par_q;
                    end else begin
                        // Current bit sits in shift_q[0]; the next one is shift_q[1].
                        bit_d   = bit_q + 4'd1;
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 8'd1;
                end
            end
            ST_PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                    txd_d   = 1'b1;
                end else begin
                    baud_d = baud_q + 8'd1;
                end
            end
            ST_STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_IDLE;
                    txd_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    baud_d = baud_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.TxD  = txd_q;
    assign bus.Busy = busy_q;
    assign bus.Done = done_q;

endmodule

// File: tb/tb_mu0_reg12_tx.sv
// Randomised bench for mu0_reg12_tx at CLKS_PER_BIT 4 and 1 against a frame-bit reference model.
module tb_mu0_reg12_tx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mu0_reg12_tx_if if4 ();
    mu0_reg12_tx_if if1 ();

    mu0_reg12_tx #(.CLKS_PER_BIT(4)) u_dut4 (.Clk(clk), .Reset(rst), .bus(if4.slave));
    mu0_reg12_tx #(.CLKS_PER_BIT(1)) u_dut1 (.Clk(clk), .Reset(rst), .bus(if1.slave));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame bit k of word d: 0 start, 1..12 data LSB first, 13 even parity, 14 stop.
    function automatic logic frame_bit(input logic [11:0] d, input int k);
        if (k == 0)  return 1'b0;
        if (k <= 12) return d[k-1];
        if (k == 13) return ^d;
        return 1'b1;
    endfunction

    task automatic drive(input bit sel, input logic st, input logic [11:0] d);
        if (sel) begin
            if1.Start = st;
            if1.D     = d;
        end else begin
            if4.Start = st;
            if4.D     = d;
        end
    endtask

    task automatic sample(input bit sel, output logic txd, output logic busy, output logic done);
        txd  = sel ? if1.TxD  : if4.TxD;
        busy = sel ? if1.Busy : if4.Busy;
        done = sel ? if1.Done : if4.Done;
    endtask

    task automatic check_idle(input bit sel, input string tag);
        logic txd, busy, done;
        sample(sel, txd, busy, done);
        check_eq({tag, "_txd"},  txd,  1'b1);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_done"}, done, 1'b0);
    endtask

    // Called at a negedge with the DUT idle or in its Done cycle; returns at the negedge of the Done cycle.
    // noise: 0 quiet, 1 random Start/D while busy, 2 Start pulse with D=456 mid-frame.
    task automatic run_frame(input bit sel, input int cpb, input logic [11:0] d, input int noise);
        logic txd, busy, done;
        int   len;
        len = 15 * cpb;
        drive(sel, 1'b1, d);
        @(negedge clk);
        drive(sel, 1'b0, 12'($urandom));
        for (int c = 0; c < len; c++) begin
            sample(sel, txd, busy, done);
            check_eq($sformatf("cpb%0d_d%03h_txd_c%0d", cpb, d, c), txd, frame_bit(d, c / cpb));
            check_eq($sformatf("cpb%0d_d%03h_busy_c%0d", cpb, d, c), busy, 1'b1);
            check_eq($sformatf("cpb%0d_d%03h_done_c%0d", cpb, d, c), done, 1'b0);
            if (c == len - 1)
                drive(sel, 1'b0, 12'($urandom));
            else if (noise == 1)
                drive(sel, 1'($urandom_range(0, 1)), 12'($urandom));
            else if (noise == 2)
                drive(sel, (c == 20), 12'h456);
            @(negedge clk);
        end
        sample(sel, txd, busy, done);
        check_eq($sformatf("cpb%0d_d%03h_end_done", cpb, d), done, 1'b1);
        check_eq($sformatf("cpb%0d_d%03h_end_busy", cpb, d), busy, 1'b0);
        check_eq($sformatf("cpb%0d_d%03h_end_txd", cpb, d),  txd,  1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic txd, busy, done;
        rst = 1'b1;
        drive(0, 1'b0, 12'h000);
        drive(1, 1'b0, 12'h000);
        repeat (2) @(negedge clk);
        check_idle(0, "reset4");
        check_idle(1, "reset1");
        rst = 1'b0;
        @(negedge clk);
        check_idle(0, "post_reset4");

        // Directed frames, including back-to-back acceptance in the Done cycle.
        run_frame(0, 4, 12'hA5C, 0);
        run_frame(0, 4, 12'h001, 0);
        @(negedge clk);
        check_idle(0, "gap_after_001");
        run_frame(0, 4, 12'h123, 2);
        @(negedge clk);
        check_idle(0, "no_second_frame");
        repeat (5) begin
            @(negedge clk);
            check_idle(0, "no_second_frame_late");
        end

        // Abort during data bit 5 (frame cycles 24..27).
        drive(0, 1'b1, 12'hA5C);
        @(negedge clk);
        drive(0, 1'b0, 12'h000);
        repeat (25) @(negedge clk);
        sample(0, txd, busy, done);
        check_eq("abort_pre_txd", txd, frame_bit(12'hA5C, 6));
        check_eq("abort_pre_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_idle(0, "abort");
        rst = 1'b0;
        repeat (70) begin
            @(negedge clk);
            check_idle(0, "abort_quiet");
        end
        run_frame(0, 4, 12'h0F0, 0);

        // Reset beats Start on the same edge.
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1'b1, 12'hABC);
        @(negedge clk);
        check_idle(0, "rst_vs_start");
        rst = 1'b0;
        drive(0, 1'b0, 12'h000);
        repeat (4) begin
            @(negedge clk);
            check_idle(0, "rst_vs_start_after");
        end

        // Start held high at one clock per bit: 16-cycle period with one idle/Done cycle.
        drive(1, 1'b1, 12'hFFF);
        @(negedge clk);
        for (int c = 0; c < 48; c++) begin
            int k;
            k = c % 16;
            sample(1, txd, busy, done);
            if (k < 15) begin
                check_eq($sformatf("held_txd_c%0d", c),  txd,  frame_bit(12'hFFF, k));
                check_eq($sformatf("held_busy_c%0d", c), busy, 1'b1);
                check_eq($sformatf("held_done_c%0d", c), done, 1'b0);
            end else begin
                check_eq($sformatf("held_txd_c%0d", c),  txd,  1'b1);
                check_eq($sformatf("held_busy_c%0d", c), busy, 1'b0);
                check_eq($sformatf("held_done_c%0d", c), done, 1'b1);
            end
            @(negedge clk);
        end
        drive(1, 1'b0, 12'h000);
        repeat (15) @(negedge clk);
        sample(1, txd, busy, done);
        check_eq("held_last_done", done, 1'b1);
        @(negedge clk);
        check_idle(1, "held_stop");

        // Random words, gaps and busy-time noise on both rates.
        for (int i = 0; i < 20; i++) begin
            int g;
            g = $urandom_range(0, 3);
            repeat (g) begin
                @(negedge clk);
                check_idle(0, "rand4_gap");
            end
            run_frame(0, 4, 12'($urandom), 1);
        end
        for (int i = 0; i < 20; i++) begin
            int g;
            g = $urandom_range(0, 3);
            repeat (g) begin
                @(negedge clk);
                check_idle(1, "rand1_gap");
            end
            run_frame(1, 1, 12'($urandom), 1);
        end
        @(negedge clk);
        check_idle(0, "final4");
        check_idle(1, "final1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
